// File: rtl/gemm_axi_req_seq_pkg.sv
// Shared types, constants and helpers for the GEMM AXI request sequencer.
package gemm_axi_req_seq_pkg;

    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned BURST_BEATS_DEF = 16;

    typedef logic [3:0] full_type_t;

    typedef enum logic [1:0] {TypeFp32, TypeFp16, TypeInt8, TypeInt4} type_t;

    typedef enum logic [1:0] {MatA, MatB, MatC} mat_t;

    typedef enum logic [2:0] {
        StIdle, StReqA, StReqB, StReqC, StWaitComp, StReqD, StGap, StFin
    } axi_seq_state_t;

    localparam logic [2:0] SelA = 3'b100;
    localparam logic [2:0] SelB = 3'b010;
    localparam logic [2:0] SelC = 3'b001;
    localparam logic [2:0] SelD = 3'b000;

    typedef struct packed {
        logic finish;
    } AXI_in_t;

    typedef struct packed {
        logic        request_valid;
        logic [2:0]  sel;
        logic [31:0] base_addr;
        logic [31:0] recvbits;
        logic [15:0] burst_num;
        logic [15:0] burst_size;
    } AXI_out_t;

    typedef struct packed {
        logic [5:0] m;
        logic [5:0] n;
        logic [5:0] k;
    } dims_t;

    function automatic logic [5:0] elem_bits(type_t t);
        logic [5:0] w;
        unique case (t)
            TypeFp32: w = 6'd32;
            TypeFp16: w = 6'd16;
            TypeInt8: w = 6'd8;
            default:  w = 6'd4;
        endcase
        return w;
    endfunction

    function automatic dims_t shape_dims(logic [1:0] shape);
        dims_t d;
        unique case (shape)
            2'd1:    d = '{m: 6'd8,  n: 6'd32, k: 6'd16};
            2'd2:    d = '{m: 6'd32, n: 6'd8,  k: 6'd16};
            default: d = '{m: 6'd16, n: 6'd16, k: 6'd16};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/gemm_mode_decode.sv
// Combinational decode of a GEMM mode into element type, matrix dims and an illegal flag.
module gemm_mode_decode
    import gemm_axi_req_seq_pkg::*;
(
    input  full_type_t mode_i,
    output type_t      typ_o,
    output logic [5:0] m_o,
    output logic [5:0] n_o,
    output logic [5:0] k_o,
    output logic       illegal_o
);

    logic [1:0] shape;
    dims_t      dims;

    always_comb begin
        illegal_o = (mode_i >= 4'd12);
        typ_o     = TypeFp32;
        shape     = 2'd0;
        if (!illegal_o) begin
            typ_o = type_t'(2'(mode_i / 4'd3));
            shape = 2'(mode_i % 4'd3);
        end
        dims = shape_dims(shape);
        m_o  = dims.m;
        n_o  = dims.n;
        k_o  = dims.k;
    end

endmodule

// File: rtl/gemm_axi_req_seq.sv
// Sequences A/B/C load requests and the D write-back request to the AXI master.
// Optional GEMM_AXI_SKIPC_EN adds c_zero, which skips the C fetch.
module gemm_axi_req_seq
    import gemm_axi_req_seq_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned BURST_BEATS = BURST_BEATS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  full_type_t mode,
    input  AXI_in_t    axi_in,
    input  logic       compute_done,
    output AXI_out_t   axi_out,
    output mat_t       load_mat,
    output logic       busy,
    output logic       done,
    output logic       err
`ifdef GEMM_AXI_SKIPC_EN
    ,
    input  logic       c_zero
`endif
);

    type_t      dec_typ;
    logic [5:0] dec_m, dec_n, dec_k;
    logic       dec_illegal;

    gemm_mode_decode u_decode (
        .mode_i    (mode),
        .typ_o     (dec_typ),
        .m_o       (dec_m),
        .n_o       (dec_n),
        .k_o       (dec_k),
        .illegal_o (dec_illegal)
    );

    logic [31:0] w_c, a_bits_c, b_bits_c, cd_bits_c;
    logic [31:0] b_base_c, c_base_c, d_base_c;

    always_comb begin
        w_c       = 32'(elem_bits(dec_typ));
        a_bits_c  = 32'(dec_m) * 32'(dec_k) * w_c;
        b_bits_c  = 32'(dec_k) * 32'(dec_n) * w_c;
        cd_bits_c = 32'(dec_m) * 32'(dec_n) * 32'd32;
        b_base_c  = a_bits_c >> 3;
        c_base_c  = b_base_c + (b_bits_c >> 3);
        d_base_c  = c_base_c + (cd_bits_c >> 3);
    end

    function automatic AXI_out_t make_req(logic vld, logic [2:0] sel, logic [31:0] base,
                                          logic [31:0] bits);
        AXI_out_t    r;
        logic [31:0] beats;
        beats           = bits / DATA_W;
        r.request_valid = vld;
        r.sel           = sel;
        r.base_addr     = base;
        r.recvbits      = bits;
        if (beats <= BURST_BEATS) begin
            r.burst_size = 16'(beats);
            r.burst_num  = 16'd1;
        end else begin
            r.burst_size = 16'(BURST_BEATS);
            r.burst_num  = 16'((beats + BURST_BEATS - 1) / BURST_BEATS);
        end
        return r;
    endfunction

    axi_seq_state_t state_q, state_d, gap_next_q, gap_next_d;
    logic [31:0]    b_base_q, b_base_d, c_base_q, c_base_d, d_base_q, d_base_d;
    logic [31:0]    b_bits_q, b_bits_d, cd_bits_q, cd_bits_d;
    AXI_out_t       axi_out_q, axi_out_d;
    mat_t           load_mat_q, load_mat_d;
    logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic           skip_c;
    logic           fin_ok;

`ifdef GEMM_AXI_SKIPC_EN
    logic skip_c_q, skip_c_d;
    assign skip_c = skip_c_q;
`else
    assign skip_c = 1'b0;
`endif

    // A finish only counts against a request that is actually on the bus.
    assign fin_ok = axi_in.finish && axi_out_q.request_valid;

    always_comb begin
        state_d    = state_q;
        gap_next_d = gap_next_q;
        b_base_d   = b_base_q;
        c_base_d   = c_base_q;
        d_base_d   = d_base_q;
        b_bits_d   = b_bits_q;
        cd_bits_d  = cd_bits_q;
        axi_out_d  = axi_out_q;
        load_mat_d = load_mat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef GEMM_AXI_SKIPC_EN
        skip_c_d   = skip_c_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (dec_illegal) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = StReqA;
                        b_base_d   = b_base_c;
                        c_base_d   = c_base_c;
                        d_base_d   = d_base_c;
                        b_bits_d   = b_bits_c;
                        cd_bits_d  = cd_bits_c;
                        axi_out_d  = make_req(1'b1, SelA, 32'd0, a_bits_c);
                        load_mat_d = MatA;
`ifdef GEMM_AXI_SKIPC_EN
                        skip_c_d   = c_zero;
`endif
                    end
                end
            end
            StReqA: begin
                if (fin_ok) begin
                    state_d    = StGap;
                    gap_next_d = StReqB;
                    axi_out_d  = make_req(1'b0, SelB, b_base_q, b_bits_q);
                    load_mat_d = MatB;
                end
            end
            StReqB: begin
                if (fin_ok) begin
                    state_d    = StGap;
                    load_mat_d = MatC;
                    if (skip_c) begin
                        gap_next_d = StWaitComp;
                        axi_out_d  = make_req(1'b0, SelD, d_base_q, cd_bits_q);
                    end else begin
                        gap_next_d = StReqC;
                        axi_out_d  = make_req(1'b0, SelC, c_base_q, cd_bits_q);
                    end
                end
            end
            StReqC: begin
                if (fin_ok) begin
                    state_d                 = StWaitComp;
                    axi_out_d.request_valid = 1'b0;
                end
            end
            StWaitComp: begin
                if (compute_done) begin
                    state_d    = StGap;
                    gap_next_d = StReqD;
                    axi_out_d  = make_req(1'b0, SelD, d_base_q, cd_bits_q);
                end
            end
            StGap: begin
                state_d = gap_next_q;
                if (gap_next_q != StWaitComp) begin
                    axi_out_d.request_valid = 1'b1;
                end
            end
            StReqD: begin
                if (fin_ok) begin
                    state_d                 = StFin;
                    axi_out_d.request_valid = 1'b0;
                    done_d                  = 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gap_next_q <= StIdle;
            b_base_q   <= '0;
            c_base_q   <= '0;
            d_base_q   <= '0;
            b_bits_q   <= '0;
            cd_bits_q  <= '0;
            axi_out_q  <= '0;
            load_mat_q <= MatA;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef GEMM_AXI_SKIPC_EN
            skip_c_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gap_next_q <= gap_next_d;
            b_base_q   <= b_base_d;
            c_base_q   <= c_base_d;
            d_base_q   <= d_base_d;
            b_bits_q   <= b_bits_d;
            cd_bits_q  <= cd_bits_d;
            axi_out_q  <= axi_out_d;
            load_mat_q <= load_mat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef GEMM_AXI_SKIPC_EN
            skip_c_q   <= skip_c_d;
`endif
        end
    end

    assign axi_out  = axi_out_q;
    assign load_mat = load_mat_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_gemm_axi_req_seq.sv
// Directed bench for gemm_axi_req_seq; covers the c_zero path when GEMM_AXI_SKIPC_EN is defined.
module tb_gemm_axi_req_seq;
    import gemm_axi_req_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, compute_done;
    full_type_t mode;
    AXI_in_t    axi_in;
    AXI_out_t   axi_out;
    mat_t       load_mat;
    logic       busy, done, err;
    int         total = 0;
    int         bad   = 0;
`ifdef GEMM_AXI_SKIPC_EN
    logic       c_zero;
    logic       skip_mon   = 1'b0;
    logic       sel_c_seen = 1'b0;
`endif

    always #5 clk = ~clk;

    gemm_axi_req_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .axi_in       (axi_in),
        .compute_done (compute_done),
        .axi_out      (axi_out),
        .load_mat     (load_mat),
        .busy         (busy),
        .done         (done),
        .err          (err)
`ifdef GEMM_AXI_SKIPC_EN
        ,
        .c_zero       (c_zero)
`endif
    );

`ifdef GEMM_AXI_SKIPC_EN
    always @(negedge clk) if (skip_mon && axi_out.sel == 3'b001) sel_c_seen = 1'b1;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_seq(input logic [3:0] m);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Check an active request, hold it for two more cycles, then complete it.
    task automatic serve(input string tag, input logic [2:0] sel, input logic [31:0] base,
                         input logic [31:0] bits, input logic [31:0] num,
                         input logic [31:0] size, input bit poke_cd);
        chk({tag, "_vld"}, 32'(axi_out.request_valid), 32'd1);
        chk({tag, "_sel"}, 32'(axi_out.sel), 32'(sel));
        chk({tag, "_base"}, axi_out.base_addr, base);
        chk({tag, "_bits"}, axi_out.recvbits, bits);
        chk({tag, "_num"}, 32'(axi_out.burst_num), num);
        chk({tag, "_size"}, 32'(axi_out.burst_size), size);
        tick();
        if (poke_cd) compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        chk({tag, "_hold"}, 32'(axi_out.request_valid), 32'd1);
        axi_in.finish = 1'b1;
        tick();
        axi_in.finish = 1'b0;
        chk({tag, "_gap"}, 32'(axi_out.request_valid), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        compute_done  = 1'b0;
        axi_in.finish = 1'b0;
        mode          = 4'd0;
`ifdef GEMM_AXI_SKIPC_EN
        c_zero        = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("rst_vld", 32'(axi_out.request_valid), 32'd0);
        chk("rst_sel", 32'(axi_out.sel), 32'd0);
        chk("rst_mat", 32'(load_mat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // FP32 m16n16k16 with stray finish / busy start in WAIT_COMP
        start_seq(4'd0);
        chk("fp32_busy", 32'(busy), 32'd1);
        serve("fp32_a", 3'b100, 32'd0, 32'd8192, 32'd16, 32'd16, 1'b0);
        chk("fp32_gap_sel", 32'(axi_out.sel), 32'd2);
        tick();
        serve("fp32_b", 3'b010, 32'd1024, 32'd8192, 32'd16, 32'd16, 1'b0);
        tick();
        serve("fp32_c", 3'b001, 32'd2048, 32'd8192, 32'd16, 32'd16, 1'b0);
        axi_in.finish = 1'b1;
        tick();
        axi_in.finish = 1'b0;
        chk("stray_fin_vld", 32'(axi_out.request_valid), 32'd0);
        chk("stray_fin_sel", 32'(axi_out.sel), 32'd1);
        start_seq(4'd13);
        tick();
        chk("busy_start_vld", 32'(axi_out.request_valid), 32'd0);
        chk("busy_start_err", 32'(err), 32'd0);
        chk("busy_start_done", 32'(done), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        chk("d_gap_vld", 32'(axi_out.request_valid), 32'd0);
        chk("d_gap_sel", 32'(axi_out.sel), 32'd0);
        tick();
        serve("fp32_d", 3'b000, 32'd3072, 32'd8192, 32'd16, 32'd16, 1'b0);
        chk("fp32_done", 32'(done), 32'd1);
        chk("fp32_done_err", 32'(err), 32'd0);
        chk("fp32_done_busy", 32'(busy), 32'd1);
        tick();
        chk("fp32_done_clr", 32'(done), 32'd0);
        chk("fp32_idle_busy", 32'(busy), 32'd0);

        // INT4 m8n32k16 with early compute_done during B
        start_seq(4'd10);
        serve("int4_a", 3'b100, 32'd0, 32'd512, 32'd1, 32'd16, 1'b0);
        tick();
        serve("int4_b", 3'b010, 32'd64, 32'd2048, 32'd4, 32'd16, 1'b1);
        tick();
        serve("int4_c", 3'b001, 32'd320, 32'd8192, 32'd16, 32'd16, 1'b0);
        tick();
        chk("early_cd_ignored", 32'(axi_out.request_valid), 32'd0);
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        tick();
        serve("int4_d", 3'b000, 32'd1344, 32'd8192, 32'd16, 32'd16, 1'b0);
        tick();

        // FP16 m32n8k16
        start_seq(4'd5);
        serve("fp16_a", 3'b100, 32'd0, 32'd8192, 32'd16, 32'd16, 1'b0);
        tick();
        serve("fp16_b", 3'b010, 32'd1024, 32'd2048, 32'd4, 32'd16, 1'b0);
        tick();
        serve("fp16_c", 3'b001, 32'd1280, 32'd8192, 32'd16, 32'd16, 1'b0);
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        tick();
        chk("fp16_d_mat", 32'(load_mat), 32'd2);
        serve("fp16_d", 3'b000, 32'd2304, 32'd8192, 32'd16, 32'd16, 1'b0);
        tick();

        // Illegal mode
        start_seq(4'd13);
        chk("ill_done", 32'(done), 32'd1);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_vld", 32'(axi_out.request_valid), 32'd0);
        tick();
        chk("ill_done_clr", 32'(done), 32'd0);
        chk("ill_err_clr", 32'(err), 32'd0);
        chk("ill_busy", 32'(busy), 32'd0);
        chk("ill_vld2", 32'(axi_out.request_valid), 32'd0);

        // Reset during REQ_B, then restart
        start_seq(4'd0);
        serve("rb_a", 3'b100, 32'd0, 32'd8192, 32'd16, 32'd16, 1'b0);
        tick();
        chk("rb_reqb_vld", 32'(axi_out.request_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_vld", 32'(axi_out.request_valid), 32'd0);
        chk("rb_busy", 32'(busy), 32'd0);
        chk("rb_sel", 32'(axi_out.sel), 32'd0);
        chk("rb_mat", 32'(load_mat), 32'd0);
        tick();
        chk("rb_idle_vld", 32'(axi_out.request_valid), 32'd0);
        start_seq(4'd0);
        chk("rb_restart_sel", 32'(axi_out.sel), 32'd4);
        chk("rb_restart_vld", 32'(axi_out.request_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

`ifdef GEMM_AXI_SKIPC_EN
        c_zero   = 1'b1;
        skip_mon = 1'b1;
        start_seq(4'd0);
        c_zero = 1'b0;
        serve("sk_a", 3'b100, 32'd0, 32'd8192, 32'd16, 32'd16, 1'b0);
        tick();
        serve("sk_b", 3'b010, 32'd1024, 32'd8192, 32'd16, 32'd16, 1'b0);
        chk("sk_gap_sel", 32'(axi_out.sel), 32'd0);
        tick();
        chk("sk_wait_vld", 32'(axi_out.request_valid), 32'd0);
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        tick();
        serve("sk_d", 3'b000, 32'd3072, 32'd8192, 32'd16, 32'd16, 1'b0);
        chk("sk_done", 32'(done), 32'd1);
        tick();
        skip_mon = 1'b0;
        chk("sk_no_sel_c", 32'(sel_c_seen), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
